// File: rtl/cbx_pkg.sv
// Shared constants and elaboration-time helpers for the parameterised connection box.
package cbx_pkg;

  localparam int unsigned CBX_CHAN_WIDTH = 20;
  localparam int unsigned CBX_NUM_IPIN   = 7;
  localparam int unsigned CBX_MUX_SIZE   = 8;
  localparam int unsigned CBX_STRIDE     = 6;

  // Smallest r with 2**r >= v.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned b = 0; b < 31; b++) begin
      if ((32'd1 << b) < v) r = b + 1;
    end
    return r;
  endfunction

  // Track feeding input k of mux i; pairs of inputs share a track index.
  function automatic int unsigned tap_idx(input int unsigned i, input int unsigned k,
                                          input int unsigned stride, input int unsigned chan);
    return (i + (k / 2) * stride) % chan;
  endfunction

endpackage

// File: rtl/cbx_cfg_chain.sv
// Serial configuration chain: shift register, bit counter, shadowed active config.
module cbx_cfg_chain
  import cbx_pkg::*;
#(
  parameter int unsigned CFG_BITS = 21
) (
  input  logic                prog_clk,
  input  logic                pReset_n,
  input  logic                ccff_head,
  input  logic                ccff_en,
  input  logic                cfg_load,
  output logic                ccff_tail,
  output logic [CFG_BITS-1:0] active_cfg,
  output logic                cfg_valid,
  output logic                cfg_err
);

  localparam int unsigned CNT_W = clog2(CFG_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_BITS);

  logic [1:0]          rst_sync_q;
  logic                rst_int_n;
  logic [CFG_BITS-1:0] sr_q, sr_d;
  logic [CFG_BITS-1:0] act_q, act_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                valid_q, valid_d;
  logic                err_q, err_d;

  // Assert asynchronously, release two prog_clk edges later.
  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) rst_sync_q <= 2'b00;
    else           rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_int_n = rst_sync_q[1];

  always_comb begin
    sr_d    = sr_q;
    act_d   = act_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    err_d   = 1'b0;
    if (ccff_en) begin
      sr_d = {sr_q[CFG_BITS-2:0], ccff_head};
      if (cnt_q != CNT_FULL) cnt_d = cnt_q + CNT_W'(1);
    end
    // Load decision always looks at the pre-edge register and count.
    if (cfg_load) begin
      if (cnt_q == CNT_FULL) begin
        act_d   = sr_q;
        valid_d = 1'b1;
        cnt_d   = ccff_en ? CNT_W'(1) : '0;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge prog_clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      sr_q    <= '0;
      act_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      sr_q    <= sr_d;
      act_q   <= act_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign ccff_tail  = sr_q[CFG_BITS-1];
  assign active_cfg = act_q;
  assign cfg_valid  = valid_q;
  assign cfg_err    = err_q;

endmodule

// File: rtl/cbx_param_cfg.sv
// Connection box: channel pass-throughs plus configurable track-to-pin muxes.
module cbx_param_cfg
  import cbx_pkg::*;
#(
  parameter int unsigned CHAN_WIDTH = CBX_CHAN_WIDTH,
  parameter int unsigned NUM_IPIN   = CBX_NUM_IPIN,
  parameter int unsigned MUX_SIZE   = CBX_MUX_SIZE,
  parameter int unsigned STRIDE     = CBX_STRIDE
) (
  input  logic                  prog_clk,
  input  logic                  pReset_n,
  input  logic [CHAN_WIDTH-1:0] chanx_left_in,
  input  logic [CHAN_WIDTH-1:0] chanx_right_in,
  output logic [CHAN_WIDTH-1:0] chanx_left_out,
  output logic [CHAN_WIDTH-1:0] chanx_right_out,
  input  logic                  ccff_head,
  input  logic                  ccff_en,
  input  logic                  cfg_load,
  output logic                  ccff_tail,
  output logic [NUM_IPIN-1:0]   ipin_out,
  output logic                  cfg_valid,
  output logic                  cfg_err
);

  localparam int unsigned SEL_W    = clog2(MUX_SIZE);
  localparam int unsigned CFG_BITS = NUM_IPIN * SEL_W;
  localparam int unsigned NSLOT    = 1 << SEL_W;

  logic [CFG_BITS-1:0] active_cfg;
  logic [NSLOT-1:0]    mux_in [NUM_IPIN];

  assign chanx_left_out  = chanx_right_in;
  assign chanx_right_out = chanx_left_in;

  cbx_cfg_chain #(
    .CFG_BITS (CFG_BITS)
  ) u_chain (
    .prog_clk   (prog_clk),
    .pReset_n   (pReset_n),
    .ccff_head  (ccff_head),
    .ccff_en    (ccff_en),
    .cfg_load   (cfg_load),
    .ccff_tail  (ccff_tail),
    .active_cfg (active_cfg),
    .cfg_valid  (cfg_valid),
    .cfg_err    (cfg_err)
  );

  // Unused select codes map to tied-low slots so out-of-range selects read 0.
  for (genvar gi = 0; gi < NUM_IPIN; gi++) begin : g_ipin
    for (genvar gk = 0; gk < NSLOT; gk++) begin : g_slot
      if (gk < MUX_SIZE) begin : g_tap
        localparam int unsigned TAP = tap_idx(gi, gk, STRIDE, CHAN_WIDTH);
        if (gk % 2 == 0) begin : g_left
          assign mux_in[gi][gk] = chanx_left_in[TAP];
        end else begin : g_right
          assign mux_in[gi][gk] = chanx_right_in[TAP];
        end
      end else begin : g_tie
        assign mux_in[gi][gk] = 1'b0;
      end
    end
  end

  always_comb begin
    ipin_out = '0;
    if (cfg_valid) begin
      for (int i = 0; i < NUM_IPIN; i++) begin
        ipin_out[i] = mux_in[i][active_cfg[i*SEL_W +: SEL_W]];
      end
    end
  end

endmodule

// File: doc/cbx_param_cfg.md
CBX_PARAM_CFG -- requirements
Module: cbx_param_cfg

Interface
REQ-001 SHALL have parameter CHAN_WIDTH, default 20, tracks per direction.
REQ-002 SHALL have parameter NUM_IPIN, default 7, number of grid-pin muxes.
REQ-003 SHALL have parameter MUX_SIZE, default 8, inputs per mux (even, 2..32).
REQ-004 SHALL have parameter STRIDE, default 6, track spacing between taps of one mux.
REQ-005 SHALL derive SEL_W = clog2(MUX_SIZE) and CFG_BITS = NUM_IPIN*SEL_W (default 21).
REQ-006 SHALL have port prog_clk  in  1  configuration clock, the only clock.
REQ-007 SHALL have port pReset_n  in  1  asynchronous active-low reset.
REQ-008 SHALL have port chanx_left_in  in  CHAN_WIDTH  left channel tracks.
REQ-009 SHALL have port chanx_right_in  in  CHAN_WIDTH  right channel tracks.
REQ-010 SHALL have port chanx_left_out  out  CHAN_WIDTH  pass-through of chanx_right_in.
REQ-011 SHALL have port chanx_right_out  out  CHAN_WIDTH  pass-through of chanx_left_in.
REQ-012 SHALL have port ccff_head  in  1  serial config data in.
REQ-013 SHALL have port ccff_en  in  1  shift enable for config chain.
REQ-014 SHALL have port cfg_load  in  1  single-cycle request: copy shift register to active config.
REQ-015 SHALL have port ccff_tail  out  1  serial config data out (shift register MSB).
REQ-016 SHALL have port ipin_out  out  NUM_IPIN  mux outputs to grid pins.
REQ-017 SHALL have port cfg_valid  out  1  active config loaded since reset.
REQ-018 SHALL have port cfg_err  out  1  one-cycle pulse: load rejected.

Function
REQ-019 Pass-throughs SHALL be purely combinational, zero latency.
REQ-020 Mux i input k SHALL be track t=(i + (k/2)*STRIDE) mod CHAN_WIDTH, from chanx_left_in for even k, chanx_right_in for odd k.
REQ-021 When ccff_en=1 on a prog_clk rising edge, shift register SHALL update to {sr[CFG_BITS-2:0], ccff_head}; otherwise hold.
REQ-022 ccff_tail SHALL equal sr[CFG_BITS-1] (registered, one bit per enabled cycle).
REQ-023 A shift counter SHALL increment per enabled shift, saturating at CFG_BITS.
REQ-024 cfg_load with counter==CFG_BITS SHALL copy pre-edge sr into active config, set cfg_valid, clear counter next cycle.
REQ-025 cfg_load with counter!=CFG_BITS SHALL leave active config and cfg_valid unchanged, pulse cfg_err one cycle, keep counter.
REQ-026 cfg_load and ccff_en in the same cycle: load/error decision SHALL use pre-edge sr and counter; shift still occurs; after accepted load counter SHALL be 1.
REQ-027 Mux i select SHALL be active[i*SEL_W +: SEL_W]; ipin_out[i] SHALL be its selected input combinationally.
REQ-028 Select value >= MUX_SIZE SHALL drive ipin_out[i]=0.
REQ-029 While cfg_valid=0, ipin_out SHALL be all-zero regardless of active config.
REQ-030 Active config SHALL never change during shifting (glitch-free routing during reprogramming).

Reset
REQ-031 pReset_n low SHALL asynchronously clear sr, active config, counter, cfg_valid, cfg_err; release synchronous to prog_clk.
REQ-032 Reset values: ccff_tail=0, cfg_valid=0, cfg_err=0, ipin_out=0; pass-throughs unaffected.
REQ-033 Reset mid-shift or mid-load SHALL discard partial config; a full CFG_BITS reshift SHALL be required.

Structure
REQ-034 Shared package cbx_pkg SHALL hold clog2 function, tap-index function, default parameter constants.
REQ-035 Sub-module cbx_cfg_chain SHALL hold shift register, counter, active config, cfg_valid/cfg_err; top holds muxes and pass-throughs.

Verification (defaults)
REQ-036 Reset, then chanx_left_in=20'hFFFFF -> ipin_out=0, cfg_valid=0, chanx_right_out=20'hFFFFF.
REQ-037 Shift 21 bits putting select 3 into mux 0 (others 0), cfg_load, chanx_right_in[6]=1 else 0 -> ipin_out[0]=1, cfg_valid=1 next cycle.
REQ-038 Shift 20 bits then cfg_load -> cfg_err high exactly one cycle, cfg_valid and ipin_out unchanged.
REQ-039 After valid config, shift 21 new bits -> ipin_out stable throughout; changes only on cycle after cfg_load.
REQ-040 Shift 42 known bits -> ccff_tail reproduces first 21 bits in order starting at shift 22.
REQ-041 Assert pReset_n low mid-shift (bit 10) -> all registers 0 immediately; following cfg_load -> cfg_err pulse.
